// File: rtl/vid_sync_gen_pkg.sv
// Purpose: shared raster-timing types and widths for the vid_sync_gen slice.
// Contents: counter/phase widths, count ceiling and the per-axis state encoding.
package vid_sync_gen_pkg;

  localparam int unsigned CNT_W   = 12;
  localparam int unsigned PC_W    = 4;
  localparam int unsigned CNT_MAX = 4095;
  localparam int unsigned DIV_MAX = 16;

  // Per-axis timing region; the same encoding serves horizontal and vertical.
  typedef enum logic [1:0] {
    AXIS_ACTIVE = 2'd0,
    AXIS_FP     = 2'd1,
    AXIS_SYNC   = 2'd2,
    AXIS_BP     = 2'd3
  } axis_state_e;

endpackage

// File: rtl/vid_axis_counter.sv
// Purpose: one raster axis (pixels in a line or lines in a frame): position
//          counter plus ACTIVE/FP/SYNC/BP region FSM, all registered together.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_step         advance one position
//   i_load_last    load the last position (reset-equivalent), overrides i_step
//   o_count        position 0..TOTAL-1
//   o_state        current region (axis_state_e encoding)
//   o_de           region == ACTIVE
//   o_sync         region == SYNC
//   o_wrap_c       combinational: position is the last one of the axis
module vid_axis_counter
  import vid_sync_gen_pkg::*;
#(
  parameter int unsigned RES  = 640,
  parameter int unsigned FP   = 16,
  parameter int unsigned SYNC = 96,
  parameter int unsigned BP   = 48
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_step,
  input  logic             i_load_last,
  output logic [CNT_W-1:0] o_count,
  output logic [1:0]       o_state,
  output logic             o_de,
  output logic             o_sync,
  output logic             o_wrap_c
);

  localparam int unsigned TOTAL = RES + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] END_ACTIVE = CNT_W'(RES - 1);
  localparam logic [CNT_W-1:0] END_FP     = CNT_W'(RES + FP - 1);
  localparam logic [CNT_W-1:0] END_SYNC   = CNT_W'(RES + FP + SYNC - 1);
  localparam logic [CNT_W-1:0] END_BP     = CNT_W'(TOTAL - 1);

  axis_state_e      r_state;
  axis_state_e      w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_de;
  logic             r_sync;

  // State/count register; de and sync are registered from the next state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= AXIS_BP;
      r_count <= END_BP;
      r_de    <= 1'b0;
      r_sync  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_de    <= (w_state_nxt == AXIS_ACTIVE);
      r_sync  <= (w_state_nxt == AXIS_SYNC);
    end
  end

  // Next count and region; each region ends on its last position.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    if (i_load_last) begin
      w_state_nxt = AXIS_BP;
      w_count_nxt = END_BP;
    end else if (i_step) begin
      w_count_nxt = (r_count == END_BP) ? '0 : r_count + CNT_W'(1);
      case (r_state)
        AXIS_ACTIVE: if (r_count == END_ACTIVE) w_state_nxt = AXIS_FP;
        AXIS_FP:     if (r_count == END_FP)     w_state_nxt = AXIS_SYNC;
        AXIS_SYNC:   if (r_count == END_SYNC)   w_state_nxt = AXIS_BP;
        AXIS_BP:     if (r_count == END_BP)     w_state_nxt = AXIS_ACTIVE;
        default:     w_state_nxt = AXIS_BP;
      endcase
    end
  end

  assign o_count  = r_count;
  assign o_state  = r_state;
  assign o_de     = r_de;
  assign o_sync   = r_sync;
  assign o_wrap_c = (r_count == END_BP);

endmodule

// File: rtl/vid_sync_gen.sv
// Purpose: raster timing generator. Sub-pixel phase counter, restart handling
//          and line/frame strobes around two vid_axis_counter instances. Every
//          timing output except pc_ena moves only on a pixel boundary, so all
//          are aligned and stable across a full pixel period.
// Ports:
//   pclk, reset          pixel clock, asynchronous active-high reset
//   run                  1 = advance, 0 = freeze everything including pc_ena
//   restart              pulse; re-phase to reset state at next pixel boundary
//   pc_ena[3:0]          sub-pixel phase 0..PIX_CLK_DIV-1
//   hde, vde, hs, vs     display enables and active-high syncs
//   h_count, v_count     raster coordinates
//   line_start           high for the pixel with h_count==0
//   frame_start          high for the pixel with h_count==0 && v_count==0
module vid_sync_gen
  import vid_sync_gen_pkg::*;
#(
  parameter int unsigned H_RES       = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned PIX_CLK_DIV = 1
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        run,
  input  logic        restart,
  output logic [3:0]  pc_ena,
  output logic        hde,
  output logic        vde,
  output logic        hs,
  output logic        vs,
  output logic [11:0] h_count,
  output logic [11:0] v_count,
  output logic        line_start,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PIX_CLK_DIV - 1);

  // Elaboration-time parameter checks.
  if (H_TOTAL > CNT_MAX) begin : g_bad_h_total
    $error("vid_sync_gen: H_TOTAL exceeds 4095");
  end
  if (V_TOTAL > CNT_MAX) begin : g_bad_v_total
    $error("vid_sync_gen: V_TOTAL exceeds 4095");
  end
  if (PIX_CLK_DIV < 1 || PIX_CLK_DIV > DIV_MAX) begin : g_bad_div
    $error("vid_sync_gen: PIX_CLK_DIV must be 1..16");
  end
  if (H_BP < 1 || V_BP < 1) begin : g_bad_bp
    $error("vid_sync_gen: back porch must be at least 1");
  end

  logic [PC_W-1:0]  r_pc_ena;
  logic             r_restart_pend;
  logic             r_line_start;
  logic             r_frame_start;

  logic             w_boundary;
  logic             w_restart_now;
  logic             w_load;
  logic             w_h_step;
  logic             w_v_step;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic [1:0]       w_h_state;
  logic [1:0]       w_v_state;
  logic [CNT_W-1:0] w_h_count;
  logic [CNT_W-1:0] w_v_count;

  // A restart arriving on the boundary edge itself applies at that edge.
  assign w_boundary    = run && (r_pc_ena == PC_LAST);
  assign w_restart_now = restart || r_restart_pend;
  assign w_load        = w_boundary && w_restart_now;
  assign w_h_step      = w_boundary && !w_restart_now;
  assign w_v_step      = w_h_step && w_h_wrap;

  // Sub-pixel phase; frozen while run is low, untouched by restart.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_pc_ena <= '0;
    end else if (run) begin
      r_pc_ena <= (r_pc_ena == PC_LAST) ? '0 : r_pc_ena + PC_W'(1);
    end
  end

  // Pending restart held until consumed by a boundary, even across run=0.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_restart_pend <= 1'b0;
    end else if (w_boundary) begin
      r_restart_pend <= 1'b0;
    end else if (restart) begin
      r_restart_pend <= 1'b1;
    end
  end

  // Strobes reflect the position the counters move to on this boundary.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (w_load) begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (w_h_step) begin
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_h_wrap && w_v_wrap;
    end
  end

  vid_axis_counter #(
    .RES  (H_RES),
    .FP   (H_FP),
    .SYNC (H_SYNC),
    .BP   (H_BP)
  ) u_h_axis (
    .i_clk       (pclk),
    .i_rst       (reset),
    .i_step      (w_h_step),
    .i_load_last (w_load),
    .o_count     (w_h_count),
    .o_state     (w_h_state),
    .o_de        (hde),
    .o_sync      (hs),
    .o_wrap_c    (w_h_wrap)
  );

  vid_axis_counter #(
    .RES  (V_RES),
    .FP   (V_FP),
    .SYNC (V_SYNC),
    .BP   (V_BP)
  ) u_v_axis (
    .i_clk       (pclk),
    .i_rst       (reset),
    .i_step      (w_v_step),
    .i_load_last (w_load),
    .o_count     (w_v_count),
    .o_state     (w_v_state),
    .o_de        (vde),
    .o_sync      (vs),
    .o_wrap_c    (w_v_wrap)
  );

  // Registered enables must always agree with the region they decode.
  a_h_region: assert property (@(posedge pclk) disable iff (reset)
    (hde == (w_h_state == AXIS_ACTIVE)) && (hs == (w_h_state == AXIS_SYNC)));
  a_v_region: assert property (@(posedge pclk) disable iff (reset)
    (vde == (w_v_state == AXIS_ACTIVE)) && (vs == (w_v_state == AXIS_SYNC)));

  assign pc_ena      = r_pc_ena;
  assign h_count     = w_h_count;
  assign v_count     = w_v_count;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule
